pcnt: RTL and testbench
=======================

# pcnt

Parametrised successor to the 4-bit hex up-counter. It is an up/down counter with a configurable width and modulus, a built-in prescaler, and selectable wrap or saturate behaviour at the bounds. It also has a synchronous parallel load and registered terminal-count and step strobes for cascading. It sits between a free-running system clock and display/timing logic that previously used the fixed hex counter.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits.
- `MAX`, default 15: highest count value; the count range is 0..MAX. Requires MAX ≤ 2^WIDTH−1 and MAX ≥ 1.
- `PRESCALE`, default 1: enabled clock cycles per count step. Requires PRESCALE ≥ 1. The internal prescaler width is ceil(log2(PRESCALE)), minimum 1.

Ports:
- `pcnt_clk` in, 1: the single clock; all state updates on the rising edge.
- `pcnt_rst` in, 1: reset, asynchronous and active-low.
- `pcnt_en` in, 1: count enable; gates the prescaler.
- `pcnt_dir` in, 1: direction; 1 = up, 0 = down.
- `pcnt_sat` in, 1: bound mode; 1 = saturate at the bound, 0 = wrap.
- `pcnt_load` in, 1: synchronous parallel load.
- `pcnt_din` in, WIDTH: load value.
- `pcnt_out` out, WIDTH: current count (registered).
- `pcnt_tc` out, 1: terminal-count strobe (registered, one cycle).
- `pcnt_step` out, 1: step strobe, high for one cycle after each count step (registered).

## Operation
- Reset (`pcnt_rst`=0), asynchronous:
  - `pcnt_out`=0, prescaler=0, `pcnt_tc`=0, `pcnt_step`=0, immediately with no clock needed.
  - Held for as long as reset is low.
- Priority at each edge, highest first: load, then tick, then hold.
- Load (`pcnt_load`=1):
  - `pcnt_out` ← `pcnt_din`; if `pcnt_din` > MAX, load MAX instead (clamp).
  - Prescaler ← 0; `pcnt_tc` ← 0; `pcnt_step` ← 0.
  - Load ignores `pcnt_en`.
- Prescaler, when not loading:
  - If `pcnt_en`=1: when prescaler == PRESCALE−1, a tick occurs and the prescaler ← 0; otherwise prescaler+1.
  - If `pcnt_en`=0: the prescaler holds its value (it is not cleared) and no tick occurs.
- Tick behaviour, up (`pcnt_dir`=1):
  - out < MAX: out+1, tc=0.
  - out == MAX: wrap to 0 (`pcnt_sat`=0) or hold MAX (`pcnt_sat`=1); tc=1 in both modes.
- Tick behaviour, down (`pcnt_dir`=0):
  - out > 0: out−1, tc=0.
  - out == 0: wrap to MAX (`pcnt_sat`=0) or hold 0 (`pcnt_sat`=1); tc=1 in both modes.
- `pcnt_step`=1 on every tick, including saturated holds.
- On any edge without a tick: `pcnt_tc`=0 and `pcnt_step`=0.
- Changing `pcnt_dir` or `pcnt_sat` mid-prescale has no effect on the prescaler; the new value applies at the next tick.
- Arithmetic is modulo MAX+1 in wrap mode. `pcnt_out` never exceeds MAX.

## Timing
- Tick edge: `pcnt_out`, `pcnt_tc` and `pcnt_step` all update on the same rising edge. The strobes are high for exactly the cycle following that edge.
- From prescaler=0 with `pcnt_en` held at 1, the first step occurs at the PRESCALE-th rising edge, then every PRESCALE edges after that.
- PRESCALE=1: a step occurs on every enabled edge, and `pcnt_step` stays high continuously while enabled.
- Load takes effect at the next edge (1-cycle latency). The new value is visible in the following cycle.
- Reset deassertion is asynchronous into the flops. The first count is possible at the PRESCALE-th enabled edge after release.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Async reset: WIDTH=4, MAX=9, PRESCALE=3, counting up at out=6. Drop `pcnt_rst` between clock edges → out=0, tc=0, step=0 before the next edge. Release → the first step to 1 occurs 3 edges after release.
- Up wrap: MAX=9, PRESCALE=3, en=1, dir=1, sat=0 from 0. Over 30 edges out goes 0..9 then 0, changing every 3 edges. tc is high for exactly 1 cycle at the 9→0 step; step pulses 10 times.
- Down saturate: MAX=9, PRESCALE=3. Load 2, then dir=0, sat=1 → out goes 2, 1, 0, 0, 0 across ticks. tc is high on the tick of each hold at 0 and low on the 2→1 and 1→0 ticks.
- Load priority and clamp: with `pcnt_load`=1 and `pcnt_din`=12 on the same edge as a pending tick → out=9, tc=0, step=0, prescaler cleared. The next step occurs 3 enabled edges later.
- Enable hold: PRESCALE=3. After 2 enabled edges, drop en for 10 edges → out is unchanged and there are no strobes. Re-raise en → the step occurs on the 1st enabled edge.
- Full-width wrap: WIDTH=8, MAX=255, PRESCALE=1. Load 254, up, wrap → out goes 255, 0, 1, with tc high only in the cycle after the 255→0 edge.

Source files
------------

// File: rtl/pcnt.sv
// Parametrised up/down counter with prescaler, wrap/saturate bounds, clamped
// parallel load and registered terminal-count / step strobes for cascading.
module pcnt #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int PRESCALE = 1
) (
    input  logic             pcnt_clk,
    input  logic             pcnt_rst,
    input  logic             pcnt_en,
    input  logic             pcnt_dir,
    input  logic             pcnt_sat,
    input  logic             pcnt_load,
    input  logic [WIDTH-1:0] pcnt_din,
    output logic [WIDTH-1:0] pcnt_out,
    output logic             pcnt_tc,
    output logic             pcnt_step
);

    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             step_q, step_d;
    logic             at_top_s, at_bot_s;

    assign at_top_s = (cnt_q == MAX_V);
    assign at_bot_s = (cnt_q == {WIDTH{1'b0}});

    // Next-state: load beats tick beats hold; strobes are high only on tick edges.
    always_comb begin
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        tc_d   = 1'b0;
        step_d = 1'b0;
        if (pcnt_load) begin
            if (pcnt_din > MAX_V) begin
                cnt_d = MAX_V;
            end else begin
                cnt_d = pcnt_din;
            end
            pre_d = {PW{1'b0}};
        end else if (pcnt_en) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = {PW{1'b0}};
                step_d = 1'b1;
                if (pcnt_dir) begin
                    if (at_top_s) begin
                        tc_d = 1'b1;
                        if (pcnt_sat) begin
                            cnt_d = MAX_V;
                        end else begin
                            cnt_d = {WIDTH{1'b0}};
                        end
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1'b1);
                    end
                end else begin
                    if (at_bot_s) begin
                        tc_d = 1'b1;
                        if (pcnt_sat) begin
                            cnt_d = {WIDTH{1'b0}};
                        end else begin
                            cnt_d = MAX_V;
                        end
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1'b1);
                    end
                end
            end else begin
                pre_d = pre_q + PW'(1'b1);
            end
        end else begin
            pre_d = pre_q;
        end
    end

    // State and strobe registers with asynchronous active-low reset.
    always_ff @(posedge pcnt_clk or negedge pcnt_rst) begin
        if (!pcnt_rst) begin
            cnt_q  <= {WIDTH{1'b0}};
            pre_q  <= {PW{1'b0}};
            tc_q   <= 1'b0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            tc_q   <= tc_d;
            step_q <= step_d;
        end
    end

    assign pcnt_out  = cnt_q;
    assign pcnt_tc   = tc_q;
    assign pcnt_step = step_q;

endmodule

// File: tb/tb_pcnt.sv
// Randomised and directed self-checking bench for pcnt, comparing two
// configurations against a cycle-level arithmetic reference model.
module tb_pcnt;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_en, a_dir, a_sat, a_load;
    logic [3:0] a_din, a_out;
    logic       a_tc, a_step;
    logic       b_en, b_dir, b_sat, b_load;
    logic [7:0] b_din, b_out;
    logic       b_tc, b_step;

    int n_checks = 0;
    int n_fail   = 0;
    int ma_cnt, ma_pre, ma_tc, ma_st;
    int mb_cnt, mb_pre, mb_tc, mb_st;
    int tally, tally2;

    localparam int A_MAX = 9,   A_PS = 3;
    localparam int B_MAX = 255, B_PS = 1;

    pcnt #(.WIDTH(4), .MAX(A_MAX), .PRESCALE(A_PS)) u_a (
        .pcnt_clk(clk), .pcnt_rst(rst), .pcnt_en(a_en), .pcnt_dir(a_dir),
        .pcnt_sat(a_sat), .pcnt_load(a_load), .pcnt_din(a_din),
        .pcnt_out(a_out), .pcnt_tc(a_tc), .pcnt_step(a_step));

    pcnt #(.WIDTH(8), .MAX(B_MAX), .PRESCALE(B_PS)) u_b (
        .pcnt_clk(clk), .pcnt_rst(rst), .pcnt_en(b_en), .pcnt_dir(b_dir),
        .pcnt_sat(b_sat), .pcnt_load(b_load), .pcnt_din(b_din),
        .pcnt_out(b_out), .pcnt_tc(b_tc), .pcnt_step(b_step));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: count range is the ring 0..mx, a step that leaves the
    // range is a terminal count and either wraps modulo mx+1 or is discarded.
    task automatic model(input int mx, input int ps, input logic en, input logic dir,
                         input logic sat, input logic load, input int din,
                         inout int cnt, inout int pre, inout int tc, inout int st);
        int raw;
        tc = 0;
        st = 0;
        if (load) begin
            cnt = (din > mx) ? mx : din;
            pre = 0;
        end else if (en) begin
            pre = (pre + 1) % ps;
            if (pre == 0) begin
                st  = 1;
                raw = cnt + (dir ? 1 : -1);
                tc  = (raw < 0 || raw > mx) ? 1 : 0;
                if (!(tc && sat)) cnt = (raw + mx + 1) % (mx + 1);
            end
        end
    endtask

    task automatic check_all();
        check_eq("a_out",  a_out,  ma_cnt);
        check_eq("a_tc",   a_tc,   ma_tc);
        check_eq("a_step", a_step, ma_st);
        check_eq("b_out",  b_out,  mb_cnt);
        check_eq("b_tc",   b_tc,   mb_tc);
        check_eq("b_step", b_step, mb_st);
    endtask

    task automatic zero_models();
        ma_cnt = 0; ma_pre = 0; ma_tc = 0; ma_st = 0;
        mb_cnt = 0; mb_pre = 0; mb_tc = 0; mb_st = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            zero_models();
        end else begin
            model(A_MAX, A_PS, a_en, a_dir, a_sat, a_load, int'(a_din), ma_cnt, ma_pre, ma_tc, ma_st);
            model(B_MAX, B_PS, b_en, b_dir, b_sat, b_load, int'(b_din), mb_cnt, mb_pre, mb_tc, mb_st);
        end
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b0;
        a_en = 1'b0; a_dir = 1'b1; a_sat = 1'b0; a_load = 1'b0; a_din = 4'd0;
        b_en = 1'b0; b_dir = 1'b1; b_sat = 1'b0; b_load = 1'b0; b_din = 8'd0;
        zero_models();
        #2;
        check_eq("rst_out", a_out, 0);
        check_eq("rst_tc", a_tc, 0);
        check_eq("rst_step", a_step, 0);
        cycle();
        cycle();
        rst = 1'b1;

        // Up wrap over 30 edges.
        a_en = 1'b1;
        tally = 0; tally2 = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            tally  += int'(a_step);
            tally2 += int'(a_tc);
        end
        check_eq("wrap_steps", tally, 10);
        check_eq("wrap_tcs", tally2, 1);
        check_eq("wrap_end", a_out, 0);

        // Count to 6, then asynchronous reset between edges.
        for (int i = 0; i < 18; i++) cycle();
        check_eq("pre_rst_out", a_out, 6);
        rst = 1'b0;
        #2;
        zero_models();
        check_eq("arst_out", a_out, 0);
        check_eq("arst_tc", a_tc, 0);
        check_eq("arst_step", a_step, 0);
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        check_eq("rel_edge2", a_out, 0);
        cycle();
        check_eq("rel_edge3", a_out, 1);
        check_eq("rel_step3", a_step, 1);

        // Down saturate from 2.
        a_load = 1'b1; a_din = 4'd2;
        cycle();
        a_load = 1'b0; a_dir = 1'b0; a_sat = 1'b1;
        tally = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            tally += int'(a_tc);
        end
        check_eq("sat_out", a_out, 0);
        check_eq("sat_tcs", tally, 3);

        // Load priority and clamp against a pending tick.
        a_dir = 1'b1; a_sat = 1'b0;
        cycle();
        cycle();
        a_load = 1'b1; a_din = 4'd12;
        cycle();
        check_eq("clamp_out", a_out, 9);
        check_eq("clamp_tc", a_tc, 0);
        check_eq("clamp_step", a_step, 0);
        a_load = 1'b0;
        cycle();
        cycle();
        check_eq("ld_nostep", a_step, 0);
        cycle();
        check_eq("ld_step", a_step, 1);
        check_eq("ld_wrap_tc", a_tc, 1);

        // Enable hold keeps the prescaler phase.
        cycle();
        cycle();
        a_en = 1'b0;
        tally = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            tally += int'(a_step) + int'(a_tc);
        end
        check_eq("hold_strobes", tally, 0);
        a_en = 1'b1;
        cycle();
        check_eq("hold_resume", a_step, 1);

        // Full-width wrap on the 8-bit instance.
        b_en = 1'b1; b_dir = 1'b1; b_sat = 1'b0; b_load = 1'b1; b_din = 8'd254;
        cycle();
        b_load = 1'b0;
        cycle();
        check_eq("fw_255", b_out, 255);
        check_eq("fw_tc0", b_tc, 0);
        cycle();
        check_eq("fw_0", b_out, 0);
        check_eq("fw_tc1", b_tc, 1);
        cycle();
        check_eq("fw_1", b_out, 1);
        check_eq("fw_tc2", b_tc, 0);

        // Randomised operation of both instances.
        for (int i = 0; i < 600; i++) begin
            a_en   = ($urandom_range(0, 3) != 0);
            a_dir  = 1'($urandom);
            a_sat  = 1'($urandom);
            a_load = ($urandom_range(0, 15) == 0);
            a_din  = 4'($urandom);
            b_en   = ($urandom_range(0, 3) != 0);
            b_dir  = ($urandom_range(0, 7) != 0) ? b_dir : ~b_dir;
            b_sat  = 1'($urandom);
            b_load = ($urandom_range(0, 31) == 0);
            b_din  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 5));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
